// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and helpers for the pong game-state sequencer.
// State encodings are shared with pong_graph and the text overlay.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_OVER    = 2'b10,
    ST_NEWBALL = 2'b11
  } state_t;

  localparam int TIMER_W = 7;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] d1, input logic [3:0] d0);
    logic [7:0] res;
    if (d0 == 4'd9) begin
      if (d1 == 4'd9) res = 8'h00;
      else            res = {d1 + 4'd1, 4'd0};
    end else begin
      res = {d1, d0 + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/pong_delay_timer.sv
// Frame-based down-counter; a load takes priority over a coincident frame tick.
// Also reusable by the text-blink logic.
module pong_delay_timer
  import pong_game_ctrl_pkg::*;
#(
  parameter int LOAD_VAL = 120
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_frame_tick,
  output logic [TIMER_W-1:0] o_count,
  output logic               o_timer_up
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_count <= '0;
    else if (i_load)
      r_count <= TIMER_W'(LOAD_VAL);
    else if (i_frame_tick && (r_count != '0))
      r_count <= r_count - TIMER_W'(1);
  end

  assign o_count    = r_count;
  assign o_timer_up = (r_count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-state sequencer: state FSM, BCD score, balls remaining and delay timer.
// state   | meaning
// NEWGAME | score cleared, waiting for any button
// PLAY    | ball live, hit scores, miss costs a ball
// NEWBALL | ball parked, wait for timer then button
// OVER    | game over, wait for timer then back to NEWGAME
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int BALLS        = 3,
  parameter int BALL_W       = 2,
  parameter int TIMER_FRAMES = 120
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_frame_tick,
  input  logic [1:0]        i_btn1,
  input  logic [1:0]        i_btn2,
  input  logic              i_hit,
  input  logic              i_miss,
  output logic [1:0]        o_game_state,
  output logic              o_gra_still,
  output logic [3:0]        o_dig0,
  output logic [3:0]        o_dig1,
  output logic [BALL_W-1:0] o_balls_left,
  output logic              o_timer_up
);

  localparam logic [BALL_W-1:0] BALLS_INIT = BALL_W'(BALLS);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_any_btn;
  logic               w_timer_up;
  logic [TIMER_W-1:0] w_timer_count;
  logic [3:0]         r_dig0;
  logic [3:0]         r_dig1;
  logic [BALL_W-1:0]  r_balls;
  logic [7:0]         w_score_inc;

  assign w_any_btn   = (|i_btn1) | (|i_btn2);
  assign w_score_inc = bcd_inc(r_dig1, r_dig0);

  pong_delay_timer #(
    .LOAD_VAL(TIMER_FRAMES)
  ) u_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_frame_tick(i_frame_tick),
    .o_count     (w_timer_count),
    .o_timer_up  (w_timer_up)
  );

  always_comb begin
    assert (w_timer_up == (w_timer_count == '0));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_NEWGAME;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_NEWGAME: begin
        if (w_any_btn) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (i_miss) begin
          w_load       = 1'b1;
          w_state_next = (r_balls > BALL_W'(1)) ? ST_NEWBALL : ST_OVER;
        end
      end
      ST_NEWBALL: begin
        if (w_timer_up && w_any_btn) w_state_next = ST_PLAY;
      end
      ST_OVER: begin
        if (w_timer_up) w_state_next = ST_NEWGAME;
      end
      default: w_state_next = ST_NEWGAME;
    endcase
  end

  // Entering or staying in NEWGAME keeps the score and ball count at their start values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dig0  <= 4'd0;
      r_dig1  <= 4'd0;
      r_balls <= BALLS_INIT;
    end else if (w_state_next == ST_NEWGAME) begin
      r_dig0  <= 4'd0;
      r_dig1  <= 4'd0;
      r_balls <= BALLS_INIT;
    end else if (r_state == ST_PLAY) begin
      if (i_hit) begin
        r_dig1 <= w_score_inc[7:4];
        r_dig0 <= w_score_inc[3:0];
      end
      if (i_miss && (r_balls != '0))
        r_balls <= r_balls - BALL_W'(1);
    end
  end

  assign o_game_state = r_state;
  assign o_gra_still  = (r_state != ST_PLAY);
  assign o_dig0       = r_dig0;
  assign o_dig1       = r_dig1;
  assign o_balls_left = r_balls;
  assign o_timer_up   = w_timer_up;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with hand-computed expectations.
module tb_pong_game_ctrl;

  logic       i_clk;
  logic       i_reset;
  logic       i_frame_tick;
  logic [1:0] i_btn1;
  logic [1:0] i_btn2;
  logic       i_hit;
  logic       i_miss;
  logic [1:0] o_game_state;
  logic       o_gra_still;
  logic [3:0] o_dig0;
  logic [3:0] o_dig1;
  logic [1:0] o_balls_left;
  logic       o_timer_up;

  int n_checks = 0;
  int n_pass   = 0;

  pong_game_ctrl #(
    .BALLS(3), .BALL_W(2), .TIMER_FRAMES(120)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_frame_tick(i_frame_tick),
    .i_btn1      (i_btn1),
    .i_btn2      (i_btn2),
    .i_hit       (i_hit),
    .i_miss      (i_miss),
    .o_game_state(o_game_state),
    .o_gra_still (o_gra_still),
    .o_dig0      (o_dig0),
    .o_dig1      (o_dig1),
    .o_balls_left(o_balls_left),
    .o_timer_up  (o_timer_up)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic hits(input int n);
    i_hit = 1'b1;
    repeat (n) tick();
    i_hit = 1'b0;
  endtask

  task automatic frames(input int n);
    i_frame_tick = 1'b1;
    repeat (n) tick();
    i_frame_tick = 1'b0;
  endtask

  task automatic press1();
    i_btn1 = 2'b01;
    tick();
    i_btn1 = 2'b00;
  endtask

  task automatic chk_score(input string tag, input int d1, input int d0);
    chk({tag, "_dig1"}, int'(o_dig1), d1);
    chk({tag, "_dig0"}, int'(o_dig0), d0);
  endtask

  initial begin
    i_reset = 1'b1; i_frame_tick = 1'b0; i_btn1 = 2'b00; i_btn2 = 2'b00;
    i_hit = 1'b0; i_miss = 1'b0;
    #2;
    chk("rst_state", int'(o_game_state), 0);
    chk("rst_still", int'(o_gra_still), 1);
    chk("rst_balls", int'(o_balls_left), 3);
    chk("rst_timer_up", int'(o_timer_up), 1);
    chk_score("rst", 0, 0);
    tick();
    i_reset = 1'b0;

    // idle newgame ignores hits
    hits(2);
    chk("newgame_idle_state", int'(o_game_state), 0);
    chk_score("newgame_hit", 0, 0);

    press1();
    chk("start_state", int'(o_game_state), 1);
    chk("start_still", int'(o_gra_still), 0);
    hits(7);
    chk_score("score07", 0, 7);

    // asynchronous reset mid-play, no clock edge needed
    #2 i_reset = 1'b1;
    #1;
    chk("midrst_state", int'(o_game_state), 0);
    chk("midrst_still", int'(o_gra_still), 1);
    chk("midrst_balls", int'(o_balls_left), 3);
    chk_score("midrst", 0, 0);
    tick();
    i_reset = 1'b0;

    press1();
    chk("restart_state", int'(o_game_state), 1);
    hits(10);
    chk_score("score10", 1, 0);
    hits(89);
    chk_score("score99", 9, 9);
    hits(1);
    chk_score("wrap00", 0, 0);

    // miss with a coincident frame tick: load must win
    i_btn2 = 2'b10;
    i_miss = 1'b1; i_frame_tick = 1'b1;
    tick();
    i_miss = 1'b0; i_frame_tick = 1'b0;
    chk("miss1_state", int'(o_game_state), 3);
    chk("miss1_balls", int'(o_balls_left), 2);
    chk("miss1_timer_up", int'(o_timer_up), 0);
    chk("miss1_still", int'(o_gra_still), 1);
    hits(1);
    chk_score("newball_hit", 0, 0);
    frames(119);
    chk("nb_119_timer_up", int'(o_timer_up), 0);
    chk("nb_119_state", int'(o_game_state), 3);
    frames(1);
    chk("nb_120_timer_up", int'(o_timer_up), 1);
    chk("nb_120_state", int'(o_game_state), 3);
    tick();
    chk("resume_state", int'(o_game_state), 1);
    i_btn2 = 2'b00;

    // hit and miss together from 09 with two balls left
    hits(9);
    chk_score("score09", 0, 9);
    i_hit = 1'b1; i_miss = 1'b1;
    tick();
    i_hit = 1'b0; i_miss = 1'b0;
    chk_score("hitmiss", 1, 0);
    chk("hitmiss_balls", int'(o_balls_left), 1);
    chk("hitmiss_state", int'(o_game_state), 3);
    frames(120);
    tick();
    chk("nb_nobtn_state", int'(o_game_state), 3);
    press1();
    chk("resume2_state", int'(o_game_state), 1);

    // last ball lost
    i_miss = 1'b1;
    tick();
    i_miss = 1'b0;
    chk("over_state", int'(o_game_state), 2);
    chk("over_balls", int'(o_balls_left), 0);
    chk("over_still", int'(o_gra_still), 1);
    hits(1);
    chk_score("over_hit", 1, 0);
    frames(119);
    chk("over_119_state", int'(o_game_state), 2);
    frames(1);
    chk("over_120_timer_up", int'(o_timer_up), 1);
    tick();
    chk("back_newgame_state", int'(o_game_state), 0);
    chk_score("back_newgame", 0, 0);
    chk("back_newgame_balls", int'(o_balls_left), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-state sequencer for the pong datapath. Consumes hit/miss pulses from pong_graph and player buttons, and produces gra_still to freeze or release the ball and paddles. Maintains a 2-digit BCD score, a balls-remaining count and a frame-based delay timer. Sits in top between vga_sync/pong_graph and the text/score overlay.

Parameters:
BALLS, 3, balls per game; legal range 1..3.
BALL_W, 2, width of balls_left.
TIMER_FRAMES, 120, frame_ticks of delay in newball/over (about 2 s at 60 Hz); legal range 1..127.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame (pixel_x==0 && pixel_y==0 qualified by p_tick)
btn1  in  2  player-1 buttons, already debounced, level
btn2  in  2  player-2 buttons, already debounced, level
hit  in  1  one-cycle pulse from pong_graph, ball returned by paddle
miss  in  1  one-cycle pulse from pong_graph, ball lost
game_state  out  2  current state encoding
gra_still  out  1  1 = graphics frozen/ball parked
dig0  out  4  score BCD units
dig1  out  4  score BCD tens
balls_left  out  BALL_W  balls remaining
timer_up  out  1  delay timer at zero

Behaviour:
- States and encoding: newgame=2'b00, play=2'b01, over=2'b10, newball=2'b11. game_state is the registered state.
- Reset (async, takes effect immediately): state=newgame, dig0=dig1=0, balls_left=BALLS, timer=0 (timer_up=1), gra_still=1.
- any_btn = |btn1 | |btn2.
- gra_still is 0 only in play; it is a combinational decode of the state, so it changes in the same cycle as the state.
- newgame: dig0/dig1 held at 0, balls_left=BALLS. If any_btn is set at a clock edge, go to play.
- play:
  - hit: score +1 in BCD. dig0 9->0 carries into dig1. 99 wraps to 00.
  - miss with balls_left>1: balls_left-1, load timer, go to newball.
  - miss with balls_left==1: balls_left=0, load timer, go to over.
  - hit and miss in the same cycle: apply both (score increments and the miss is handled).
- newball: stay until timer_up && any_btn, then go to play. A button held throughout is accepted on the first cycle timer_up is 1.
- over: when timer_up, go to newgame. Entering newgame clears the score and reloads balls_left=BALLS in the same transition cycle.
- hit/miss outside play: ignored, with no score or ball change.
- Timer:
  - 7-bit down-counter, loaded with TIMER_FRAMES on the transition cycle into newball or over.
  - Decrements on frame_tick while nonzero. timer_up = (count==0), combinational.
  - A load on the same cycle as a frame_tick: the load wins.
  - Exactly TIMER_FRAMES frame_ticks after entry, timer_up rises.
- No internal edge detection on buttons: level sampling only.
- Latency: every state/score/ball update is visible one clk after the qualifying input edge.

Decomposition:
- pong_defs.vh (shared include): state encodings (NEWGAME, PLAY, OVER, NEWBALL). pong_graph and the text overlay use the same encodings.
- One sub-module: pong_delay_timer (load, frame_tick, count, timer_up), reusable by the text-blink logic.
- BCD score counter stays inline.

Test Plan:
- Reset mid-play (state=play, score=07): assert reset -> game_state=00, dig1:dig0=00, balls_left=3, gra_still=1 with no clk edge required.
- Reset, btn1=2'b01 one cycle -> next cycle game_state=01, gra_still=0. Then 10 hit pulses -> dig1=1, dig0=0. Then from score 99, one hit -> 00.
- In play with balls_left=3: miss -> game_state=11, balls_left=2, timer_up=0. After 119 frame_ticks timer_up=0, after 120 timer_up=1. btn2 held throughout -> play on the first cycle timer_up=1.
- Three misses (with resumes between) -> game_state=10, balls_left=0. 120 frame_ticks -> game_state=00, score 00, balls_left=3.
- hit and miss together with score 09, balls_left=2 -> score 10, balls_left=1, state newball. hit pulses in newball/over/newgame -> score unchanged.
- Timer load coinciding with frame_tick on the miss cycle -> count=TIMER_FRAMES, not TIMER_FRAMES-1.
